// File: rtl/tft_seq_pkg.sv
// Shared types and constants for the frame sequencer and its watchdog.
package tft_seq_pkg;

  localparam int ROI_W = 12;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_CHECK     = 4'd1,
    ST_START     = 4'd2,
    ST_WAIT_BUSY = 4'd3,
    ST_WAIT_DONE = 4'd4,
    ST_GAP       = 4'd5,
    ST_DONE      = 4'd6,
    ST_ABORT     = 4'd7,
    ST_ERROR     = 4'd8
  } seq_state_e;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_BAD_CFG  = 3'd1,
    ERR_BUSY_TO  = 3'd2,
    ERR_FRAME_TO = 3'd3,
    ERR_ABORTED  = 3'd4
  } err_code_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Cycle counter shared by every timed state; expires once the count reaches the limit.
module seq_watchdog (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_enable,
  input  logic [31:0] i_limit,
  output logic        o_expired
);

  logic [31:0] r_count;

  // Holds at all-ones instead of wrapping so a stuck state never looks fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != 32'hFFFF_FFFF)) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign o_expired = (r_count >= i_limit);

endmodule

// File: rtl/frame_sequencer.sv
// Host-side initiator for timing_generator: latches and validates an acquisition,
// launches frames with an inter-frame gap and supervises each with a watchdog.
module frame_sequencer
  import tft_seq_pkg::*;
#(
  parameter int unsigned START_PULSE_CYC = 2,
  parameter int unsigned BUSY_TIMEOUT    = 1024,
  parameter int unsigned FRAME_TIMEOUT   = 5_000_000,
  parameter int unsigned GAP_CYC         = 16,
  parameter int unsigned RESET_CYC       = 4,
  parameter int unsigned MAX_ROWS        = 3072,
  parameter int unsigned MAX_COLS        = 3072
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_start,
  input  logic             cmd_abort,
  input  logic [15:0]      cfg_integration,
  input  logic [ROI_W-1:0] cfg_row_start,
  input  logic [ROI_W-1:0] cfg_row_end,
  input  logic [ROI_W-1:0] cfg_col_start,
  input  logic [ROI_W-1:0] cfg_col_end,
  input  logic [15:0]      cfg_frame_count,
  output logic             frame_start,
  output logic             frame_reset,
  output logic [15:0]      integration_time,
  output logic [ROI_W-1:0] row_start,
  output logic [ROI_W-1:0] row_end,
  output logic [ROI_W-1:0] col_start,
  output logic [ROI_W-1:0] col_end,
  input  logic             frame_busy,
  input  logic             frame_complete,
  output logic             seq_busy,
  output logic             seq_done,
  output logic             seq_error,
  output logic [2:0]       err_code,
  output logic [15:0]      frames_done
);

  // Watchdog limits are one less than the cycle count because the counter starts at 0.
  localparam logic [31:0] LIM_START = START_PULSE_CYC - 1;
  localparam logic [31:0] LIM_BUSY  = BUSY_TIMEOUT - 1;
  localparam logic [31:0] LIM_FRAME = FRAME_TIMEOUT - 1;
  localparam logic [31:0] LIM_GAP   = GAP_CYC - 1;
  localparam logic [31:0] LIM_RESET = RESET_CYC - 1;

  seq_state_e       r_state;
  seq_state_e       w_next;
  err_code_e        r_err_code;
  err_code_e        w_err_val;
  logic             w_err_set;
  logic             w_start_acc;
  logic             w_frame_inc;
  logic             w_abort_req;
  logic             w_completion;
  logic             w_cfg_bad;
  logic             w_wd_clear;
  logic             w_wd_expired;
  logic [31:0]      w_limit;
  logic [15:0]      w_frames_inc;

  logic [15:0]      r_integration;
  logic [ROI_W-1:0] r_row_start;
  logic [ROI_W-1:0] r_row_end;
  logic [ROI_W-1:0] r_col_start;
  logic [ROI_W-1:0] r_col_end;
  logic [15:0]      r_frame_count;
  logic [15:0]      r_frames_done;
  logic             r_seq_error;
  logic             r_seq_done;
  logic             r_busy_q;

  assign w_cfg_bad = (r_integration == 16'd0) ||
                     (r_row_start > r_row_end) ||
                     (r_col_start > r_col_end) ||
                     (32'(r_row_end) >= MAX_ROWS) ||
                     (32'(r_col_end) >= MAX_COLS);

  // A busy falling edge counts as completion for generators that only report by level.
  assign w_completion = frame_complete || (r_busy_q && !frame_busy);
  assign w_frames_inc = sat_inc16(r_frames_done);

  always_comb begin
    w_abort_req = 1'b0;
    case (r_state)
      ST_CHECK, ST_START, ST_WAIT_BUSY, ST_WAIT_DONE, ST_GAP: w_abort_req = cmd_abort;
      default:                                                w_abort_req = 1'b0;
    endcase
  end

  always_comb begin
    w_next      = r_state;
    w_err_set   = 1'b0;
    w_err_val   = ERR_NONE;
    w_start_acc = 1'b0;
    w_frame_inc = 1'b0;
    if (w_abort_req) begin
      w_next    = ST_ABORT;
      w_err_set = 1'b1;
      w_err_val = ERR_ABORTED;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (cmd_start && !cmd_abort) begin
            w_next      = ST_CHECK;
            w_start_acc = 1'b1;
          end
        end
        ST_CHECK: begin
          if (w_cfg_bad) begin
            w_next    = ST_ERROR;
            w_err_set = 1'b1;
            w_err_val = ERR_BAD_CFG;
          end else begin
            w_next = ST_START;
          end
        end
        ST_START: begin
          if (w_wd_expired) w_next = ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (frame_busy) begin
            w_next = ST_WAIT_DONE;
          end else if (w_wd_expired) begin
            w_next    = ST_ABORT;
            w_err_set = 1'b1;
            w_err_val = ERR_BUSY_TO;
          end
        end
        ST_WAIT_DONE: begin
          if (w_completion) begin
            w_frame_inc = 1'b1;
            if ((r_frame_count != 16'd0) && (w_frames_inc == r_frame_count)) begin
              w_next = ST_DONE;
            end else begin
              w_next = ST_GAP;
            end
          end else if (w_wd_expired) begin
            w_next    = ST_ABORT;
            w_err_set = 1'b1;
            w_err_val = ERR_FRAME_TO;
          end
        end
        ST_GAP: begin
          if (w_wd_expired) w_next = ST_START;
        end
        ST_ABORT: begin
          if (w_wd_expired) w_next = ST_ERROR;
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_limit = 32'd0;
    case (r_state)
      ST_START:     w_limit = LIM_START;
      ST_WAIT_BUSY: w_limit = LIM_BUSY;
      ST_WAIT_DONE: w_limit = LIM_FRAME;
      ST_GAP:       w_limit = LIM_GAP;
      ST_ABORT:     w_limit = LIM_RESET;
      default:      w_limit = 32'd0;
    endcase
  end

  assign w_wd_clear = (w_next != r_state);

  seq_watchdog u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_wd_clear),
    .i_enable  (seq_busy),
    .i_limit   (w_limit),
    .o_expired (w_wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_err_code    <= ERR_NONE;
      r_frames_done <= '0;
      r_seq_error   <= 1'b0;
      r_seq_done    <= 1'b0;
      r_busy_q      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_busy_q   <= frame_busy;
      r_seq_done <= (w_next == ST_DONE) && (r_state != ST_DONE);
      if (w_start_acc) begin
        r_err_code    <= ERR_NONE;
        r_frames_done <= '0;
        r_seq_error   <= 1'b0;
      end else begin
        if (w_err_set)   r_err_code    <= w_err_val;
        if (w_frame_inc) r_frames_done <= w_frames_inc;
        if (w_next == ST_ERROR) r_seq_error <= 1'b1;
      end
    end
  end

  // Shadows only move on an accepted start, so they are frozen for the whole sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_integration <= '0;
      r_row_start   <= '0;
      r_row_end     <= '0;
      r_col_start   <= '0;
      r_col_end     <= '0;
      r_frame_count <= '0;
    end else if (w_start_acc) begin
      r_integration <= cfg_integration;
      r_row_start   <= cfg_row_start;
      r_row_end     <= cfg_row_end;
      r_col_start   <= cfg_col_start;
      r_col_end     <= cfg_col_end;
      r_frame_count <= cfg_frame_count;
    end
  end

  assign frame_start      = (r_state == ST_START);
  assign frame_reset      = (r_state == ST_ABORT);
  assign seq_busy         = (r_state != ST_IDLE) && (r_state != ST_DONE) && (r_state != ST_ERROR);
  assign seq_done         = r_seq_done;
  assign seq_error        = r_seq_error;
  assign err_code         = r_err_code;
  assign frames_done      = r_frames_done;
  assign integration_time = r_integration;
  assign row_start        = r_row_start;
  assign row_end          = r_row_end;
  assign col_start        = r_col_start;
  assign col_end          = r_col_end;

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer with a behavioural timing_generator model and a result scoreboard.
module tb_frame_sequencer;

  localparam int GAP_CYC       = 16;
  localparam int BUSY_TIMEOUT  = 1024;
  localparam int FRAME_TIMEOUT = 3000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_start = 1'b0;
  logic        cmd_abort = 1'b0;
  logic [15:0] cfg_integration = '0;
  logic [11:0] cfg_row_start = '0, cfg_row_end = '0, cfg_col_start = '0, cfg_col_end = '0;
  logic [15:0] cfg_frame_count = '0;
  logic        frame_start, frame_reset;
  logic [15:0] integration_time;
  logic [11:0] row_start, row_end, col_start, col_end;
  logic        frame_busy = 1'b0;
  logic        frame_complete = 1'b0;
  logic        seq_busy, seq_done, seq_error;
  logic [2:0]  err_code;
  logic [15:0] frames_done;

  frame_sequencer #(.FRAME_TIMEOUT(FRAME_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .cfg_integration(cfg_integration), .cfg_row_start(cfg_row_start),
    .cfg_row_end(cfg_row_end), .cfg_col_start(cfg_col_start), .cfg_col_end(cfg_col_end),
    .cfg_frame_count(cfg_frame_count), .frame_start(frame_start), .frame_reset(frame_reset),
    .integration_time(integration_time), .row_start(row_start), .row_end(row_end),
    .col_start(col_start), .col_end(col_end), .frame_busy(frame_busy),
    .frame_complete(frame_complete), .seq_busy(seq_busy), .seq_done(seq_done),
    .seq_error(seq_error), .err_code(err_code), .frames_done(frames_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] integ;
    logic [11:0] rs, re, cs, ce;
    logic [15:0] cnt;
    int          mode;   // 0 normal, 1 busy never rises, 2 frame never completes
    logic [2:0]  err;
    logic [15:0] frames;
    int          fs_n;
  } vec_t;

  typedef struct {
    logic [2:0]  err;
    logic [15:0] frames;
    logic        seq_err;
    int          done_n;
    int          fs_n;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[9];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int model_mode = 0;
  int last_cmpl_cyc = -1;
  int mon_fs_n = 0, mon_done_n = 0, mon_fr_len = 0;
  int fs_fall_cyc = 0, fr_rise_cyc = 0;
  int m_st = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic chk_range(input string name, input longint act, input longint lo, input longint hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  // Timing generator model: busy 3 cycles after frame_start falls, completes 100 cycles later.
  initial begin
    int m_cnt;
    logic m_prev_fs;
    m_cnt = 0;
    m_prev_fs = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || frame_reset) begin
        frame_busy = 1'b0;
        frame_complete = 1'b0;
        m_st = 0;
      end else begin
        frame_complete = 1'b0;
        case (m_st)
          0: if (m_prev_fs && !frame_start) begin m_cnt = 3; m_st = 1; end
          1: if (model_mode != 1) begin
               m_cnt--;
               if (m_cnt == 0) begin frame_busy = 1'b1; m_cnt = 100; m_st = 2; end
             end
          2: if (model_mode != 2) begin
               m_cnt--;
               if (m_cnt == 0) begin
                 frame_busy = 1'b0;
                 frame_complete = 1'b1;
                 last_cmpl_cyc = cyc;
                 m_st = 0;
               end
             end
          default: m_st = 0;
        endcase
      end
      m_prev_fs = frame_start;
    end
  end

  // Output monitor: pulse counts, pulse widths and inter-frame gaps.
  initial begin
    logic prev_fs, prev_fr;
    int fs_len, fr_len;
    prev_fs = 1'b0; prev_fr = 1'b0; fs_len = 0; fr_len = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (frame_start && !prev_fs) begin
          mon_fs_n++;
          fs_len = 1;
          if (last_cmpl_cyc >= 0) chk_range("gap_after_complete", cyc - last_cmpl_cyc, GAP_CYC, 1000);
        end else if (frame_start) begin
          fs_len++;
        end
        if (!frame_start && prev_fs) begin
          chk("start_pulse_len", fs_len, 2);
          fs_fall_cyc = cyc;
        end
        if (frame_reset && !prev_fr) begin fr_len = 1; fr_rise_cyc = cyc; end
        else if (frame_reset) fr_len++;
        if (!frame_reset && prev_fr) mon_fr_len = fr_len;
        if (seq_done) mon_done_n++;
      end
      prev_fs = frame_start;
      prev_fr = frame_reset;
    end
  end

  task automatic clr_mon();
    mon_fs_n = 0; mon_done_n = 0; mon_fr_len = 0; last_cmpl_cyc = -1;
  endtask

  task automatic kick(input vec_t v, input bit push);
    exp_t e;
    clr_mon();
    model_mode = v.mode;
    @(negedge clk);
    cfg_integration = v.integ; cfg_row_start = v.rs; cfg_row_end = v.re;
    cfg_col_start = v.cs; cfg_col_end = v.ce; cfg_frame_count = v.cnt;
    cmd_start = 1'b1;
    if (push) begin
      e.err = v.err; e.frames = v.frames; e.seq_err = (v.err != 3'd0);
      e.done_n = (v.err == 3'd0) ? 1 : 0; e.fs_n = v.fs_n;
      sb_q.push_back(e);
    end
    @(negedge clk);
    cmd_start = 1'b0;
    // Scramble the inputs so any leak from cfg_* into the shadows shows up.
    cfg_integration = 16'($urandom); cfg_row_start = 12'($urandom); cfg_row_end = 12'($urandom);
    cfg_col_start = 12'($urandom); cfg_col_end = 12'($urandom); cfg_frame_count = 16'($urandom);
  endtask

  task automatic finish_seq(input vec_t v);
    exp_t e;
    bit ended;
    ended = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (!seq_busy) begin ended = 1'b1; break; end
    end
    if (!ended) chk("seq_end_timeout", 0, 1);
    repeat (3) @(negedge clk);
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
    end else begin
      e = sb_q.pop_front();
      chk("err_code", err_code, e.err);
      chk("frames_done", frames_done, e.frames);
      chk("seq_error", seq_error, e.seq_err);
      chk("seq_done_pulses", mon_done_n, e.done_n);
      chk("frame_start_pulses", mon_fs_n, e.fs_n);
    end
    chk("shadow_integ", integration_time, v.integ);
    chk("shadow_row_start", row_start, v.rs);
    chk("shadow_row_end", row_end, v.re);
    chk("shadow_col_start", col_start, v.cs);
    chk("shadow_col_end", col_end, v.ce);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_frame_start"}, frame_start, 0);
    chk({tag, "_frame_reset"}, frame_reset, 0);
    chk({tag, "_seq_busy"}, seq_busy, 0);
    chk({tag, "_seq_done"}, seq_done, 0);
    chk({tag, "_seq_error"}, seq_error, 0);
    chk({tag, "_err_code"}, err_code, 0);
    chk({tag, "_frames_done"}, frames_done, 0);
    chk({tag, "_integ"}, integration_time, 0);
    chk({tag, "_row_end"}, row_end, 0);
    chk({tag, "_col_end"}, col_end, 0);
  endtask

  initial begin
    vec_t v;
    bit hit;
    //          integ  rs     re     cs     ce     cnt mode err frames fs
    vecs[0] = '{16'd1, 12'd0, 12'd0, 12'd0, 12'd0, 16'd1, 0, 3'd0, 16'd1, 1};
    vecs[1] = '{16'd5, 12'd0, 12'd3071, 12'd0, 12'd3071, 16'd3, 0, 3'd0, 16'd3, 3};
    vecs[2] = '{16'd9, 12'd10, 12'd5, 12'd0, 12'd20, 16'd1, 0, 3'd1, 16'd0, 0};
    vecs[3] = '{16'd0, 12'd0, 12'd5, 12'd0, 12'd5, 16'd1, 0, 3'd1, 16'd0, 0};
    vecs[4] = '{16'd3, 12'd0, 12'd5, 12'd7, 12'd6, 16'd1, 0, 3'd1, 16'd0, 0};
    vecs[5] = '{16'd3, 12'd0, 12'd3072, 12'd0, 12'd5, 16'd1, 0, 3'd1, 16'd0, 0};
    vecs[6] = '{16'd3, 12'd0, 12'd5, 12'd0, 12'd3072, 16'd1, 0, 3'd1, 16'd0, 0};
    vecs[7] = '{16'd7, 12'd3071, 12'd3071, 12'd3071, 12'd3071, 16'd2, 0, 3'd0, 16'd2, 2};
    vecs[8] = '{16'd2, 12'd1, 12'd2, 12'd3, 12'd4, 16'd1, 2, 3'd3, 16'd0, 1};

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      kick(vecs[i], 1'b1);
      finish_seq(vecs[i]);
      if (vecs[i].mode == 2) chk("frame_to_reset_len", mon_fr_len, 4);
    end

    // Busy never rises: watchdog abort with a 4-cycle frame_reset.
    v = '{16'd4, 12'd2, 12'd8, 12'd2, 12'd8, 16'd1, 1, 3'd2, 16'd0, 1};
    kick(v, 1'b1);
    finish_seq(v);
    chk("busy_to_reset_len", mon_fr_len, 4);
    chk_range("busy_to_latency", fr_rise_cyc - fs_fall_cyc, BUSY_TIMEOUT, BUSY_TIMEOUT + 1);

    // Continuous mode, host abort during the sixth frame.
    v = '{16'd6, 12'd0, 12'd100, 12'd0, 12'd100, 16'd0, 0, 3'd4, 16'd5, 6};
    kick(v, 1'b1);
    hit = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (frames_done == 16'd5 && frame_busy) begin hit = 1'b1; break; end
    end
    if (!hit) chk("reach_five_frames", 0, 1);
    repeat (10) @(negedge clk);
    cmd_abort = 1'b1;
    @(negedge clk);
    cmd_abort = 1'b0;
    finish_seq(v);
    chk("abort_reset_len", mon_fr_len, 4);

    // Start and abort together in ERROR: start is dropped, error stays.
    clr_mon();
    cmd_start = 1'b1; cmd_abort = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0; cmd_abort = 1'b0;
    repeat (4) @(negedge clk);
    chk("start_abort_err_busy", seq_busy, 0);
    chk("start_abort_err_code", err_code, 4);
    chk("start_abort_err_sticky", seq_error, 1);

    // Asynchronous reset in the middle of the second frame.
    v = '{16'd8, 12'd1, 12'd9, 12'd1, 12'd9, 16'd3, 0, 3'd0, 16'd3, 3};
    kick(v, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (frames_done == 16'd1 && m_st == 2) begin hit = 1'b1; break; end
    end
    if (!hit) chk("reach_second_frame", 0, 1);
    chk("pre_reset_frames", frames_done, 1);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midframe_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", seq_busy, 0);

    // Start and abort together in IDLE: nothing launches.
    clr_mon();
    cfg_integration = 16'd1; cfg_row_start = '0; cfg_row_end = 12'd4;
    cfg_col_start = '0; cfg_col_end = 12'd4; cfg_frame_count = 16'd1;
    cmd_start = 1'b1; cmd_abort = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0; cmd_abort = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_start_abort_busy", seq_busy, 0);
    chk("idle_start_abort_fs", mon_fs_n, 0);
    chk("idle_start_abort_shadow", row_end, 0);

    // Normal operation resumes after the dropped start.
    kick(vecs[0], 1'b1);
    finish_seq(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
